// File: rtl/alu_scheduler_pkg.sv
// Shared definitions for the two-client ALU scheduler: opcodes, flag bit
// positions, FSM states and the opcode legality check.
package alu_scheduler_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;
  localparam int FLAG_W = 5;

  localparam logic [OP_W-1:0] ALU_AND    = 4'b0000;
  localparam logic [OP_W-1:0] ALU_OR     = 4'b0001;
  localparam logic [OP_W-1:0] ALU_XOR    = 4'b0010;
  localparam logic [OP_W-1:0] ALU_NOR    = 4'b0011;
  localparam logic [OP_W-1:0] ALU_ADD    = 4'b0100;
  localparam logic [OP_W-1:0] ALU_SUB    = 4'b0101;
  localparam logic [OP_W-1:0] ALU_SLTU   = 4'b0110;
  localparam logic [OP_W-1:0] ALU_SHL    = 4'b0111;
  localparam logic [OP_W-1:0] ALU_INC    = 4'b1000;
  localparam logic [OP_W-1:0] ALU_OP_MAX = 4'b1000;

  localparam int FLAG_ZF = 4;
  localparam int FLAG_OF = 3;
  localparam int FLAG_SF = 2;
  localparam int FLAG_CF = 1;
  localparam int FLAG_PF = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return op > ALU_OP_MAX;
  endfunction

endpackage

// File: rtl/alu_scheduler_alu.sv
// Shared combinational ALU: result F plus raw carry-out for ADD/SUB.
module alu_scheduler_alu
  import alu_scheduler_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] f,
  output logic              cout
);

  localparam int               SH_W      = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] SHIFT_LIM = DATA_W;
  localparam logic [DATA_W-1:0] ONE       = 1;

  logic [DATA_W:0] sum_ext;

  always_comb begin
    f       = '0;
    cout    = 1'b0;
    sum_ext = '0;
    case (op)
      ALU_AND: f = a & b;
      ALU_OR:  f = a | b;
      ALU_XOR: f = a ^ b;
      ALU_NOR: f = ~(a | b);
      ALU_ADD: begin
        sum_ext = {1'b0, a} + {1'b0, b};
        f       = sum_ext[DATA_W-1:0];
        cout    = sum_ext[DATA_W];
      end
      // Subtract as A + ~B + 1 so carry-out means "no borrow"
      ALU_SUB: begin
        sum_ext = {1'b0, a} + {1'b0, ~b} + {1'b0, ONE};
        f       = sum_ext[DATA_W-1:0];
        cout    = sum_ext[DATA_W];
      end
      ALU_SLTU: f = (a < b) ? ONE : '0;
      ALU_SHL:  f = (a >= SHIFT_LIM) ? '0 : (b << a[SH_W-1:0]);
      ALU_INC:  f = a + ONE;
      default:  f = '0;
    endcase
  end

endmodule

// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one ALU between two clients: capture on
// request handshake, execute for one cycle, hold registered result until taken.
module alu_scheduler
  import alu_scheduler_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req_op0,
  input  logic [3:0]       req_op1,
  input  logic [31:0]      req_a0,
  input  logic [31:0]      req_b0,
  input  logic [31:0]      req_a1,
  input  logic [31:0]      req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [4:0]       rsp_flags,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_e              state, state_nxt;
  logic                prio;
  logic [OP_W-1:0]     cur_op;
  logic [DATA_W-1:0]   cur_a, cur_b;
  logic                cur_id;

  logic                accept, rsp_done, grant_id;
  logic [DATA_W-1:0]   alu_f;
  logic                alu_cout;
  logic                illegal, of_add, of_sub;
  logic [FLAG_W-1:0]   flags_nxt;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic [DATA_W-1:0] f,
                                                   input logic cf, input logic of);
    logic [FLAG_W-1:0] fl;
    fl          = '0;
    fl[FLAG_ZF] = (f == '0);
    fl[FLAG_OF] = of;
    fl[FLAG_SF] = f[DATA_W-1];
    fl[FLAG_CF] = cf;
    fl[FLAG_PF] = ~^f;
    return fl;
  endfunction

  // Arbitration: the prio client wins a tie; a lone requester always wins
  assign req_ready[0] = (state == ST_IDLE) & req_valid[0] & (~prio | ~req_valid[1]);
  assign req_ready[1] = (state == ST_IDLE) & req_valid[1] & ( prio | ~req_valid[0]);
  assign accept       = |(req_valid & req_ready);
  assign grant_id     = req_ready[1];
  assign rsp_done     = (state == ST_RESP) & rsp_ready[cur_id];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  alu_scheduler_alu u_alu (
    .op   (cur_op),
    .a    (cur_a),
    .b    (cur_b),
    .f    (alu_f),
    .cout (alu_cout)
  );

  assign illegal = op_illegal(cur_op);
  assign of_add  = (cur_a[DATA_W-1] == cur_b[DATA_W-1]) & (alu_f[DATA_W-1] != cur_a[DATA_W-1]);
  assign of_sub  = (cur_a[DATA_W-1] != cur_b[DATA_W-1]) & (alu_f[DATA_W-1] != cur_a[DATA_W-1]);

  always_comb begin
    flags_nxt = '0;
    if (!illegal) begin
      case (cur_op)
        ALU_ADD: flags_nxt = pack_flags(alu_f, alu_cout, of_add);
        ALU_SUB: flags_nxt = pack_flags(alu_f, alu_cout, of_sub);
        default: flags_nxt = pack_flags(alu_f, 1'b0, 1'b0);
      endcase
    end
  end

  // Capture on grant, register ALU result in EXEC, release on response handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      prio      <= 1'b0;
      cur_op    <= '0;
      cur_a     <= '0;
      cur_b     <= '0;
      cur_id    <= 1'b0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
      op_count  <= '0;
    end else begin
      if (accept) begin
        cur_op <= grant_id ? req_op1 : req_op0;
        cur_a  <= grant_id ? req_a1  : req_a0;
        cur_b  <= grant_id ? req_b1  : req_b0;
        cur_id <= grant_id;
      end
      if (state == ST_EXEC) begin
        rsp_data  <= illegal ? '0 : alu_f;
        rsp_flags <= flags_nxt;
        rsp_err   <= illegal;
        rsp_valid <= {cur_id, ~cur_id};
      end
      if (rsp_done) begin
        rsp_valid <= '0;
        prio      <= ~cur_id;
        op_count  <= op_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler: directed scenarios plus randomized
// operations against an arithmetic reference model.
module tb_alu_scheduler;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_ready;
  logic [3:0]       req_op0 = '0, req_op1 = '0;
  logic [31:0]      req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready = '0;
  logic [31:0]      rsp_data;
  logic [4:0]       rsp_flags;
  logic             rsp_err;
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  alu_scheduler #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op0   (req_op0),
    .req_op1   (req_op1),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_flags (rsp_flags),
    .rsp_err   (rsp_err),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not end, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Reference: result from plain arithmetic, flags {ZF,OF,SF,CF,PF}
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] d, output logic [4:0] f, output logic e);
    longint unsigned ua, ub;
    longint          sa, sb, r;
    logic            cf, of;
    ua = a; ub = b;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    d = '0; cf = 1'b0; of = 1'b0; e = 1'b0; r = 0;
    case (op)
      4'd0: d = a & b;
      4'd1: d = a | b;
      4'd2: d = a ^ b;
      4'd3: d = ~(a | b);
      4'd4: begin d = a + b; cf = (ua + ub) > 64'hFFFF_FFFF; r = sa + sb;
                  of = (r != longint'($signed(d))); end
      4'd5: begin d = a - b; cf = (ua >= ub); r = sa - sb;
                  of = (r != longint'($signed(d))); end
      4'd6: d = (ua < ub) ? 32'd1 : 32'd0;
      4'd7: d = (ua >= 64'd32) ? 32'd0 : (b << a);
      4'd8: d = a + 32'd1;
      default: e = 1'b1;
    endcase
    if (e) f = '0;
    else   f = {(d == 32'd0), of, d[31], cf, (($countones(d) % 2) == 0)};
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 3))
      0: return $urandom_range(0, 40);
      1: case ($urandom_range(0, 3))
           0: return 32'h7FFF_FFFF;
           1: return 32'h8000_0000;
           2: return 32'hFFFF_FFFF;
           default: return 32'h0;
         endcase
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_req(input int c, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (c == 0) begin req_op0 = op; req_a0 = a; req_b0 = b; end
    else        begin req_op1 = op; req_a1 = a; req_b1 = b; end
    req_valid[c] = 1'b1;
  endtask

  task automatic wait_ready(input int c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready[c]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // lat = number of rising edges (handshake edge included) until rsp_valid seen
  task automatic wait_rsp(input int c, output int lat);
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      #1;
      if (rsp_valid[c]) begin lat = i; break; end
      @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; rsp_ready = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
  endtask

  task automatic run_op(input int c, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int bp, output logic [31:0] d, output logic [4:0] f,
                        output logic e, output int lat);
    bit ok;
    d = '0; f = '0; e = 1'b0; lat = -1;
    @(negedge clk);
    drive_req(c, op, a, b);
    wait_ready(c, ok);
    if (!ok) begin req_valid[c] = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    req_valid[c] = 1'b0;
    wait_rsp(c, lat);
    if (lat < 0) return;
    d = rsp_data; f = rsp_flags; e = rsp_err;
    repeat (bp) @(negedge clk);
    rsp_ready[c] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[c] = 1'b0;
    exp_count++;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid} !== 4'b0) begin
      errors++; $display("FAIL reset_valids: got ready=%b valid=%b want 00/00", req_ready, rsp_valid);
    end
    checks++;
    if ({rsp_data, rsp_flags, rsp_err} !== 38'b0) begin
      errors++; $display("FAIL reset_rsp: got data=%h flags=%b err=%b want 0", rsp_data, rsp_flags, rsp_err);
    end
    checks++;
    if (op_count !== '0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", op_count);
    end
    rst = 1'b0;
    exp_count = 0;
  endtask

  task automatic test_sub_equal();
    logic [31:0] d; logic [4:0] f; logic e; int lat;
    run_op(1, 4'b0101, 32'h1234_5678, 32'h1234_5678, 0, d, f, e, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL sub_lat: got %0d want 2", lat); end
    checks++;
    if ({d, f, e} !== {32'h0, 5'b10011, 1'b0}) begin
      errors++; $display("FAIL sub_equal: got data=%h flags=%b err=%b want 0/10011/0", d, f, e);
    end
    checks++;
    if (op_count !== 16'd1) begin errors++; $display("FAIL sub_count: got %0d want 1", op_count); end
  endtask

  task automatic test_add_overflow();
    logic [31:0] d; logic [4:0] f; logic e; int lat;
    run_op(0, 4'b0100, 32'h7FFF_FFFF, 32'h1, 0, d, f, e, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL add_lat: got %0d want 2", lat); end
    checks++;
    if ({d, f, e} !== {32'h8000_0000, 5'b01100, 1'b0}) begin
      errors++; $display("FAIL add_overflow: got data=%h flags=%b err=%b want 80000000/01100/0", d, f, e);
    end
  endtask

  task automatic test_edge_ops();
    logic [31:0] d; logic [4:0] f; logic e; int lat;
    run_op(1, 4'b1011, $urandom, $urandom, 0, d, f, e, lat);
    checks++;
    if ({d, f, e} !== {32'h0, 5'b0, 1'b1} || lat !== 2) begin
      errors++; $display("FAIL illegal_op: got data=%h flags=%b err=%b lat=%0d want 0/00000/1/2", d, f, e, lat);
    end
    run_op(0, 4'b0111, 32'd40, $urandom | 32'h1, 1, d, f, e, lat);
    checks++;
    if ({d, f, e} !== {32'h0, 5'b10001, 1'b0}) begin
      errors++; $display("FAIL shl_40: got data=%h flags=%b err=%b want 0/10001/0", d, f, e);
    end
    run_op(1, 4'b0110, 32'd1, 32'hFFFF_FFFF, 0, d, f, e, lat);
    checks++;
    if ({d, f, e} !== {32'h1, 5'b00000, 1'b0}) begin
      errors++; $display("FAIL sltu: got data=%h flags=%b err=%b want 1/00000/0", d, f, e);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, d0, ed; logic [4:0] f0, ef; logic e0, ee;
    logic [CNT_W-1:0] cnt0; bit ok; int lat;
    a = $urandom; b = $urandom;
    model(4'b0100, a, b, ed, ef, ee);
    @(negedge clk);
    drive_req(0, 4'b0100, a, b);
    wait_ready(0, ok);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_rsp(0, lat);
    d0 = rsp_data; f0 = rsp_flags; e0 = rsp_err; cnt0 = op_count;
    checks++;
    if (!ok || lat !== 2 || {d0, f0, e0} !== {ed, ef, ee}) begin
      errors++; $display("FAIL bp_result: got data=%h flags=%b err=%b lat=%0d want %h/%b/%b/2",
                         d0, f0, e0, lat, ed, ef, ee);
    end
    drive_req(1, 4'b0001, $urandom, $urandom);
    rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({rsp_data, rsp_flags, rsp_err} !== {d0, f0, e0}) begin
        errors++; $display("FAIL bp_hold: got data=%h flags=%b want %h/%b", rsp_data, rsp_flags, d0, f0);
      end
      checks++;
      if (req_ready !== 2'b00 || rsp_valid !== 2'b01) begin
        errors++; $display("FAIL bp_ctrl: got ready=%b valid=%b want 00/01", req_ready, rsp_valid);
      end
      checks++;
      if (op_count !== cnt0) begin
        errors++; $display("FAIL bp_count: got %0d want %0d", op_count, cnt0);
      end
    end
    req_valid[1] = 1'b0;
    rsp_ready = 2'b01;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 2'b00;
    exp_count++;
    #1;
    checks++;
    if (op_count !== CNT_W'(exp_count) || rsp_valid !== 2'b00) begin
      errors++; $display("FAIL bp_release: got count=%0d valid=%b want %0d/00", op_count, rsp_valid, exp_count);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] op_c [2]; logic [31:0] a_c [2]; logic [31:0] b_c [2];
    logic [31:0] ed; logic [4:0] ef; logic ee; bit found; int w, lat;
    pulse_reset();
    for (int c = 0; c < 2; c++) begin
      op_c[c] = 4'($urandom_range(0, 9)); a_c[c] = rand_operand(); b_c[c] = rand_operand();
      drive_req(c, op_c[c], a_c[c], b_c[c]);
    end
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
        #1;
        if (|req_ready) begin found = 1'b1; break; end
        @(negedge clk);
      end
      checks++;
      if (!found || req_ready === 2'b11) begin
        errors++; $display("FAIL rr_grant_%0d: got ready=%b want one-hot", k, req_ready);
        break;
      end
      w = req_ready[1] ? 1 : 0;
      checks++;
      if (w !== k % 2) begin errors++; $display("FAIL rr_order_%0d: got client %0d want %0d", k, w, k % 2); end
      model(op_c[w], a_c[w], b_c[w], ed, ef, ee);
      @(posedge clk);
      @(negedge clk);
      op_c[w] = 4'($urandom_range(0, 9)); a_c[w] = rand_operand(); b_c[w] = rand_operand();
      drive_req(w, op_c[w], a_c[w], b_c[w]);
      #1;
      checks++;
      if (req_ready !== 2'b00) begin errors++; $display("FAIL rr_exec_ready: got %b want 00", req_ready); end
      wait_rsp(w, lat);
      checks++;
      if (lat !== 2 || {rsp_data, rsp_flags, rsp_err} !== {ed, ef, ee}) begin
        errors++; $display("FAIL rr_result_%0d: got data=%h flags=%b err=%b lat=%0d want %h/%b/%b/2",
                           k, rsp_data, rsp_flags, rsp_err, lat, ed, ef, ee);
      end
      checks++;
      if (req_ready !== 2'b00 || rsp_valid !== (w == 1 ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rr_resp_ctrl_%0d: got ready=%b valid=%b", k, req_ready, rsp_valid);
      end
      rsp_ready[w] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready[w] = 1'b0;
      exp_count++;
    end
    req_valid = '0;
    #1;
    checks++;
    if (op_count !== CNT_W'(exp_count)) begin
      errors++; $display("FAIL rr_count: got %0d want %0d", op_count, exp_count);
    end
  endtask

  task automatic test_reset_in_resp();
    logic [31:0] d, ed; logic [4:0] f, ef; logic e, ee; int lat; bit ok;
    pulse_reset();
    run_op(0, 4'b0000, $urandom, $urandom, 0, d, f, e, lat);
    @(negedge clk);
    drive_req(0, 4'b0100, 32'h5, 32'h7);
    wait_ready(0, ok);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_rsp(0, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL rstresp_reach: got lat %0d want 2", lat); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({req_ready, rsp_valid, rsp_data, rsp_flags, rsp_err, op_count} !== '0) begin
        errors++; $display("FAIL rstresp_outputs: got ready=%b valid=%b data=%h flags=%b err=%b count=%0d want all 0",
                           req_ready, rsp_valid, rsp_data, rsp_flags, rsp_err, op_count);
      end
      @(negedge clk);
    end
    drive_req(0, 4'b0001, 32'h1, 32'h2);
    drive_req(1, 4'b0001, 32'h3, 32'h4);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL rstresp_prio: got ready=%b want 01", req_ready); end
    req_valid = '0;
    model(4'b0101, 32'h10, 32'h3, ed, ef, ee);
    run_op(1, 4'b0101, 32'h10, 32'h3, 0, d, f, e, lat);
    checks++;
    if ({d, f, e} !== {ed, ef, ee} || op_count !== 16'd1) begin
      errors++; $display("FAIL rstresp_after: got data=%h flags=%b count=%0d want %h/%b/1", d, f, op_count, ed, ef);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, d, ed; logic [4:0] f, ef; logic e, ee; logic [3:0] op; int c, lat;
    for (int n = 0; n < 40; n++) begin
      c = $urandom_range(0, 1); op = 4'($urandom_range(0, 15));
      a = rand_operand(); b = rand_operand();
      model(op, a, b, ed, ef, ee);
      run_op(c, op, a, b, $urandom_range(0, 2), d, f, e, lat);
      checks++;
      if (lat !== 2 || {d, f, e} !== {ed, ef, ee}) begin
        errors++; $display("FAIL rand_%0d op=%h a=%h b=%h: got data=%h flags=%b err=%b lat=%0d want %h/%b/%b/2",
                           n, op, a, b, d, f, e, lat, ed, ef, ee);
      end
      checks++;
      if (op_count !== CNT_W'(exp_count)) begin
        errors++; $display("FAIL rand_count_%0d: got %0d want %0d", n, op_count, exp_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sub_equal();
    test_add_overflow();
    test_edge_ops();
    test_backpressure();
    test_simultaneous();
    test_reset_in_resp();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
